// File: rtl/pixel_frame_buffer.sv
// Single-clock ROWS x COLS pixel store: random read, raster scan with frame/line markers, sticky errors.
// Define PFB_CLAMP_EN to clamp out-of-range random reads to the nearest edge pixel.
module pixel_frame_buffer #(
    parameter int DATA_W = 12,
    parameter int COL_W  = 9,
    parameter int ROW_W  = 8,
    parameter int COLS   = 320,
    parameter int ROWS   = 240
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic [DATA_W-1:0]      i_DATA,
    input  logic                   i_WRITE,
    input  logic                   i_READ,
    input  logic [ROW_W+COL_W-1:0] i_ADDRESS,
    input  logic                   i_SCAN_START,
    input  logic                   i_READY,
    input  logic                   i_ERR_CLR,
    output logic [DATA_W-1:0]      o_DATA,
    output logic                   o_VALID,
    output logic                   o_SOF,
    output logic                   o_EOL,
    output logic                   o_EOF,
    output logic                   o_BUSY,
    output logic [1:0]             o_ERR
);
    localparam int DEPTH = ROWS * COLS;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW    = ROW_W + COL_W + 1;
    localparam logic [ROW_W:0]   ROWS_L   = (ROW_W+1)'(ROWS);
    localparam logic [COL_W:0]   COLS_L   = (COL_W+1)'(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FLUSH} state_t;

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic              eof;
        logic [DATA_W-1:0] data;
    } pix_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_ram_q;

    state_t            r_state;
    logic [ROW_W-1:0]  r_scan_row;
    logic [COL_W-1:0]  r_scan_col;
    logic              r_pend_vld, r_pend_sof, r_pend_eol, r_pend_eof, r_pend_zero;
    logic              r_skid_vld;
    pix_t              r_skid;

    logic [ROW_W-1:0]  w_row, w_rd_row;
    logic [COL_W-1:0]  w_col, w_rd_col;
    logic              w_in_range, w_wr_en, w_rd_en, w_rd_zero, w_rd_oor;
    logic [IW-1:0]     w_wr_idx, w_rd_idx;
    logic              w_xfer, w_room, w_rnd_acc, w_scan_issue;
    logic [1:0]        w_occ;
    logic              w_is_sof, w_is_eol, w_is_eof;
    logic              w_err0_set, w_err1_set;
    logic [DATA_W-1:0] w_pend_data;
    pix_t              w_pend;
    logic              w_unused;

    assign w_row      = i_ADDRESS[ROW_W+COL_W-1:COL_W];
    assign w_col      = i_ADDRESS[COL_W-1:0];
    assign w_in_range = ({1'b0, w_row} < ROWS_L) && ({1'b0, w_col} < COLS_L);
    assign w_wr_idx   = IW'(w_row) * IW'(COLS) + IW'(w_col);
    assign w_wr_en    = i_WRITE && w_in_range;

    // Items in flight (RAM stage + output register + skid) never exceed two.
    assign w_xfer       = o_VALID && i_READY;
    assign w_occ        = {1'b0, r_pend_vld} + {1'b0, o_VALID} + {1'b0, r_skid_vld};
    assign w_room       = (w_occ - {1'b0, w_xfer}) < 2'd2;
    assign w_rnd_acc    = i_READ && (r_state == ST_IDLE) && (!o_VALID || w_xfer);
    assign w_scan_issue = (r_state == ST_SCAN) && w_room;
    assign w_rd_en      = w_rnd_acc || w_scan_issue;

    assign w_is_sof = (r_scan_row == '0) && (r_scan_col == '0);
    assign w_is_eol = (r_scan_col == COL_LAST);
    assign w_is_eof = (r_scan_row == ROW_LAST) && w_is_eol;

    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_rd_row  = r_scan_row;
        w_rd_col  = r_scan_col;
        w_rd_zero = 1'b0;
        w_rd_oor  = 1'b0;
        if (r_state != ST_SCAN) begin
`ifdef PFB_CLAMP_EN
            w_rd_row = ({1'b0, w_row} < ROWS_L) ? w_row : ROW_LAST;
            w_rd_col = ({1'b0, w_col} < COLS_L) ? w_col : COL_LAST;
`else
            if (w_in_range) begin
                w_rd_row = w_row;
                w_rd_col = w_col;
            end else begin
                w_rd_row  = '0;
                w_rd_col  = '0;
                w_rd_zero = 1'b1;
                w_rd_oor  = 1'b1;
            end
`endif
        end
    end

    assign w_rd_idx   = IW'(w_rd_row) * IW'(COLS) + IW'(w_rd_col);
    assign w_err0_set = (i_WRITE && !w_in_range) || (w_rnd_acc && w_rd_oor);
    assign w_err1_set = i_READ && !w_rnd_acc;

    assign w_pend_data = r_pend_zero ? '0 : r_ram_q;
    assign w_pend      = {r_pend_sof, r_pend_eol, r_pend_eof, w_pend_data};
    assign w_unused    = ^{w_wr_idx[IW-1:IDX_W], w_rd_idx[IW-1:IDX_W]};

    // NOTE: the pixel array is never reset; clearing it would prevent RAM inference.
    always_ff @(posedge i_CLK) begin
        if (w_wr_en) r_mem[w_wr_idx[IDX_W-1:0]] <= i_DATA;
        if (w_rd_en) r_ram_q <= r_mem[w_rd_idx[IDX_W-1:0]];
    end

    // NOTE: non-blocking assignments make each register take its pre-edge inputs regardless of statement order.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state     <= ST_IDLE;
            r_scan_row  <= '0;
            r_scan_col  <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_sof  <= 1'b0;
            r_pend_eol  <= 1'b0;
            r_pend_eof  <= 1'b0;
            r_pend_zero <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid      <= '0;
            o_DATA      <= '0;
            o_VALID     <= 1'b0;
            o_SOF       <= 1'b0;
            o_EOL       <= 1'b0;
            o_EOF       <= 1'b0;
            o_BUSY      <= 1'b0;
            o_ERR       <= 2'b00;
        end else begin
            o_ERR       <= (i_ERR_CLR ? 2'b00 : o_ERR) | {w_err1_set, w_err0_set};
            r_pend_vld  <= w_rd_en;
            r_pend_sof  <= w_scan_issue && w_is_sof;
            r_pend_eol  <= w_scan_issue && w_is_eol;
            r_pend_eof  <= w_scan_issue && w_is_eof;
            r_pend_zero <= w_rnd_acc && w_rd_zero;

            if (!o_VALID || w_xfer) begin
                if (r_skid_vld) begin
                    o_VALID    <= 1'b1;
                    o_DATA     <= r_skid.data;
                    o_SOF      <= r_skid.sof;
                    o_EOL      <= r_skid.eol;
                    o_EOF      <= r_skid.eof;
                    r_skid_vld <= r_pend_vld;
                    r_skid     <= w_pend;
                end else begin
                    o_VALID <= r_pend_vld;
                    if (r_pend_vld) o_DATA <= w_pend.data;
                    o_SOF   <= w_pend.sof;
                    o_EOL   <= w_pend.eol;
                    o_EOF   <= w_pend.eof;
                end
            end else if (r_pend_vld) begin
                r_skid_vld <= 1'b1;
                r_skid     <= w_pend;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_SCAN_START) begin
                        r_state    <= ST_SCAN;
                        o_BUSY     <= 1'b1;
                        r_scan_row <= '0;
                        r_scan_col <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_scan_issue) begin
                        if (w_is_eol) begin
                            r_scan_col <= '0;
                            if (w_is_eof) begin
                                r_scan_row <= '0;
                                r_state    <= ST_FLUSH;
                            end else begin
                                r_scan_row <= r_scan_row + 1'b1;
                            end
                        end else begin
                            r_scan_col <= r_scan_col + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_xfer && o_EOF) begin
                        r_state <= ST_IDLE;
                        o_BUSY  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
